// File: rtl/tb_ram_arb_pkg.sv
// Shared types for the testbench RAM data-port arbiter: master identity,
// registered response owner, and the conflict counter ceiling.
package tb_ram_arb_pkg;

  typedef enum logic {
    CORE = 1'b0,
    LDR  = 1'b1
  } master_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic    valid;
    master_e master;
  } resp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick with loader lock override; purely combinational,
// the caller owns the priority register.
module rr_arb2
  import tb_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lock,
  input  master_e    prio,
  output logic [1:0] gnt,
  output master_e    next_prio
);

  always_comb begin
    gnt       = 2'b00;
    next_prio = prio;
    if (lock) begin
      gnt[1] = req[1];
    end else if (req == 2'b11) begin
      gnt = (prio == CORE) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    // Priority always moves to the master that was not served.
    if (gnt[0]) begin
      next_prio = LDR;
    end else if (gnt[1]) begin
      next_prio = CORE;
    end
  end

endmodule

// File: rtl/tb_ram_port_arbiter.sv
// Shares the single RAM data port between the core OBI data master and the
// testbench loader, routing each one-cycle-latency response back to its owner.
module tb_ram_port_arbiter
  import tb_ram_arb_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 18,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      core_req_i,
  output logic                      core_gnt_o,
  input  logic [31:0]               core_addr_i,
  input  logic                      core_we_i,
  input  logic [DATA_WIDTH/8-1:0]   core_be_i,
  input  logic [DATA_WIDTH-1:0]     core_wdata_i,
  output logic                      core_rvalid_o,
  output logic [DATA_WIDTH-1:0]     core_rdata_o,
  input  logic                      ldr_req_i,
  output logic                      ldr_gnt_o,
  input  logic [31:0]               ldr_addr_i,
  input  logic                      ldr_we_i,
  input  logic [DATA_WIDTH/8-1:0]   ldr_be_i,
  input  logic [DATA_WIDTH-1:0]     ldr_wdata_i,
  output logic                      ldr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     ldr_rdata_o,
  input  logic                      ldr_lock_i,
  output logic                      ram_en_o,
  output logic [RAM_ADDR_WIDTH-3:0] ram_addr_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,
  output logic [31:0]               conflict_cnt_o
);

  master_e     prio_q;
  master_e     next_prio;
  resp_t       resp_q;
  logic [31:0] conflict_cnt_q;
  logic [1:0]  gnt;
  logic [31:0] sel_addr;
  logic        conflict;
  logic        core_own;
  logic        ldr_own;
  logic        unused_addr_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  rr_arb2 u_arb (
    .req      ({ldr_req_i, core_req_i}),
    .lock     (ldr_lock_i),
    .prio     (prio_q),
    .gnt      (gnt),
    .next_prio(next_prio)
  );

  assign core_gnt_o = gnt[0];
  assign ldr_gnt_o  = gnt[1];
  assign ram_en_o   = |gnt;

  always_comb begin
    sel_addr    = core_addr_i;
    ram_we_o    = core_we_i;
    ram_be_o    = core_be_i;
    ram_wdata_o = core_wdata_i;
    if (gnt[1]) begin
      sel_addr    = ldr_addr_i;
      ram_we_o    = ldr_we_i;
      ram_be_o    = ldr_be_i;
      ram_wdata_o = ldr_wdata_i;
    end
  end

  // Out-of-range upper bits are silently dropped.
  assign ram_addr_o       = sel_addr[RAM_ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{sel_addr[31:RAM_ADDR_WIDTH], sel_addr[1:0]};

  assign conflict = (core_req_i & ~gnt[0] & gnt[1]) |
                    (ldr_req_i  & ~gnt[1] & gnt[0]);

  // Grant stage -> response stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q         <= CORE;
      resp_q         <= '{valid: 1'b0, master: CORE};
      conflict_cnt_q <= '0;
    end else begin
      prio_q        <= next_prio;
      resp_q.valid  <= |gnt;
      resp_q.master <= gnt[1] ? LDR : CORE;
      if (conflict) begin
        conflict_cnt_q <= sat_inc(conflict_cnt_q);
      end
    end
  end

  // A reset arriving while a response is pending drops it immediately.
  assign core_own = resp_q.valid & ~rst_i & (resp_q.master == CORE);
  assign ldr_own  = resp_q.valid & ~rst_i & (resp_q.master == LDR);

  assign core_rvalid_o  = core_own;
  assign ldr_rvalid_o   = ldr_own;
  assign core_rdata_o   = core_own ? ram_rdata_i : '0;
  assign ldr_rdata_o    = ldr_own  ? ram_rdata_i : '0;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule
